// File: rtl/add_seq_ctrl.sv
// Serial W-bit add/subtract controller: one nibble per cycle through a 4-bit ripple-carry slice.
// Latency: accept at edge k, out_valid high in the cycle after edge k+NNIB.
// Backpressure: result held in DONE until out_ready; in_ready low while busy, requests not queued.

// 4-bit ripple-carry adder slice
module add_seq_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[4];
endmodule

module add_seq_ctrl #(
  parameter int NNIB = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NNIB-1:0] a,
  input  logic [4*NNIB-1:0] b,
  input  logic            op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*NNIB-1:0] result,
  output logic            cout,
  output logic            zero,
  output logic            overflow,
  output logic            busy
);
  localparam int W  = 4 * NNIB;
  localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NNIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q;       // latched operand A
  logic [W-1:0]  b_q;       // latched B, already inverted for subtract
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  result_q;

  logic [3:0]    a_nib, b_nib, slice_sum;
  logic          slice_cout;
  logic          last_nib;

  // Nibble selection for the current step; the slice is shared by every nibble
  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  assign last_nib = (idx_q == LAST_IDX);

  add_seq_rca4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_nib)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded straight from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture on accept, then one nibble of sum and carry per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state_q == S_IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= b ^ {W{op}};
      carry_q <= op;            // +1 completes the two's-complement negate
      idx_q   <= '0;
    end else if (state_q == S_RUN) begin
      result_q[{idx_q, 2'b00} +: 4] <= slice_sum;
      carry_q <= slice_cout;
      idx_q   <= last_nib ? '0 : idx_q + IW'(1);
    end
  end

  assign result   = result_q;
  assign cout     = carry_q;
  assign zero     = (result_q == '0);
  assign overflow = (a_q[W-1] == b_q[W-1]) && (result_q[W-1] != a_q[W-1]);
endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout, zero, overflow, busy;

  int n_vec = 0;
  int n_err = 0;

  add_seq_ctrl #(.NNIB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after an accept edge (called at accept edge + #1)
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, out_valid, 1'b0);
    chk({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic opv,
                        input logic [15:0] er, input logic ec, input logic ez, input logic eo);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    a = av; b = bv; op = opv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hA5C3; b = 16'h3C5A; op = ~opv;   // scramble: must not disturb the operation
    chk({tag, "_busy"}, busy, 1'b1);
    wait_result(tag);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf"}, overflow, eo);
    retire(tag);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",    16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
    run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("ovf_add",16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_op("ovf_sub",16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    run_op("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE while a new request is pending
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222;              // next request, kept valid throughout
    wait_result("bp");
    chk("bp_result", result, 16'h0030);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ov", out_valid, 1'b1);
      chk("bp_hold_res", result, 16'h0030);
      chk("bp_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ov", out_valid, 1'b0);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", busy, 1'b1);
    wait_result("bp2");
    chk("bp2_result", result, 16'h3333);
    retire("bp2");

    // Reset in the middle of RUN
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_result", result, 16'h0000);
    chk("mrst_cout", cout, 1'b0);
    chk("mrst_zero", zero, 1'b1);
    chk("mrst_ovf", overflow, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("mrst_no_ov", seen, 0);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter NNIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NNIB.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  W  operand A, unsigned/two's-complement.
REQ-008 b  input  W  operand B.
REQ-009 op  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  W  sum/difference.
REQ-013 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 zero  output  1  result == 0.
REQ-015 overflow  output  1  signed overflow.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 The block SHALL compute the W-bit operation serially, one nibble per cycle, through a single internally instantiated 4-bit ripple-carry adder slice (a, b, cin -> sum, cout).
REQ-018 FSM states SHALL be IDLE, RUN, DONE; IDLE is the reset state.
REQ-019 IDLE: in_ready = 1; on in_valid = 1 at a rising edge, latch a, b XOR {W{op}}, op, set carry register = op, nibble index = 0, go to RUN.
REQ-020 Operand changes after the accept edge SHALL have no effect on the current operation.
REQ-021 RUN: each edge, add nibble[idx] of latched A and B_eff with carry register, write the 4-bit sum into result[4*idx+3:4*idx], update carry register with slice cout, increment idx.
REQ-022 RUN: on the edge processing idx = NNIB-1, go to DONE; idx wraps to 0.
REQ-023 Latency: if the request is accepted at edge k, out_valid SHALL be 1 in the cycle after edge k+NNIB (NNIB cycles); no result-valid cycle earlier.
REQ-024 DONE: out_valid = 1; result, cout, zero, overflow held stable until the handshake.
REQ-025 DONE: on out_ready = 1 at an edge, go to IDLE; out_valid falls in the next cycle.
REQ-026 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored, not queued.
REQ-027 No same-cycle result retire and new accept; minimum request spacing = NNIB+2 cycles.
REQ-028 cout SHALL equal the final carry register.
REQ-029 zero SHALL equal (result == 0), valid while out_valid = 1.
REQ-030 overflow SHALL equal (A[W-1] == B_eff[W-1]) AND (result[W-1] != A[W-1]).
REQ-031 out_valid, in_ready, busy SHALL be glitch-free register-decoded state outputs.

Reset
REQ-032 rst_n = 0 SHALL immediately, without clock, force IDLE, idx = 0, carry = 0, result = 0, cout = 0, overflow = 0, out_valid = 0, busy = 0; in_ready = 1; zero = 1.
REQ-033 Reset asserted in RUN or DONE SHALL discard the operation; no out_valid follows release.
REQ-034 After rst_n release, the first request SHALL be acceptable at the first rising edge.

Verification
REQ-035 Add: a = 0x1234, b = 0x0001, op = 0 -> after 4 cycles, result = 0x1235, cout = 0, zero = 0, overflow = 0.
REQ-036 Wrap: a = 0xFFFF, b = 0x0001, op = 0 -> result = 0x0000, cout = 1, zero = 1, overflow = 0.
REQ-037 Signed overflow: a = 0x7FFF, b = 0x0001, op = 0 -> result = 0x8000, cout = 0, overflow = 1; subtract a = 0x8000, b = 0x0001, op = 1 -> result = 0x7FFF, cout = 1, overflow = 1.
REQ-038 Borrow: a = 0x0005, b = 0x0007, op = 1 -> result = 0xFFFE, cout = 0, overflow = 0.
REQ-039 Backpressure: hold out_ready = 0 for 3 cycles in DONE while driving in_valid = 1 with new operands -> out_valid and result stay constant, in_ready = 0, new request accepted only after IDLE is re-entered.
REQ-040 Reset mid-RUN: assert rst_n = 0 after 2 nibble edges -> outputs immediately at REQ-032 values, no out_valid after release; next request 0x0001 + 0x0001 -> 0x0002.
